bus_dma: RTL and testbench



---
 rtl/bus_dma_if.sv | 31 +++
 rtl/bus_dma.sv | 135 +++++++++++++
 tb/tb_bus_dma.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_dma_if.sv
// System-bus bundle for bus_dma: responder (register) port plus initiator (master) port.
// The slave modport is the DMA engine's view; the master modport is the system/bench view.
interface bus_dma_if;
   logic [31:0] address_in;
   logic        sel_in;
   logic        read_in;
   logic [31:0] read_value_out;
   logic [3:0]  write_mask_in;
   logic [31:0] write_value_in;
   logic [31:0] address_out;
   logic        read_out;
   logic        write_out;
   logic [3:0]  write_mask_out;
   logic [31:0] write_value_out;
   logic [31:0] read_value_in;
   logic        ready_in;

   modport slave (
      input  address_in, sel_in, read_in, write_mask_in, write_value_in,
      input  read_value_in, ready_in,
      output read_value_out, address_out, read_out, write_out,
      output write_mask_out, write_value_out
   );

   modport master (
      output address_in, sel_in, read_in, write_mask_in, write_value_in,
      output read_value_in, ready_in,
      input  read_value_out, address_out, read_out, write_out,
      input  write_mask_out, write_value_out
   );
endinterface

// File: rtl/bus_dma.sv
// Word-copy DMA engine: SRC/DST/LEN/CTRL register port plus a bus initiator port.
// Optional DMA_IRQ_EN adds CTRL bit2 (ie) and a registered irq_out = done & ie.
module bus_dma #(
   parameter int LEN_WIDTH = 16
) (
   input  logic       clk,
   input  logic       reset,
   bus_dma_if.slave   bus
`ifdef DMA_IRQ_EN
   ,
   output logic       irq_out
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;

   logic [1:0]           state_reg;
   // Addresses are word-aligned, so only bits [31:2] are stored; wrap is free.
   logic [31:2]          src_reg;
   logic [31:2]          dst_reg;
   logic [LEN_WIDTH-1:0] len_reg;
   logic [31:0]          data_reg;
   logic                 done_reg;
   logic                 ie_bit;

   logic [1:0] reg_idx;
   logic       reg_wr;
   logic       ctrl_wr;
   logic       start;
   logic       clr_done;
   logic       busy;

   assign reg_idx  = bus.address_in[3:2];
   assign reg_wr   = bus.sel_in & (|bus.write_mask_in);
   assign ctrl_wr  = reg_wr & (reg_idx == 2'd3);
   assign start    = ctrl_wr & bus.write_value_in[0];
   assign clr_done = ctrl_wr & bus.write_value_in[1];
   assign busy     = (state_reg != ST_IDLE);

   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, bus.address_in[31:4], bus.address_in[1:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         src_reg   <= '0;
         dst_reg   <= '0;
         len_reg   <= '0;
         data_reg  <= '0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (reg_wr && reg_idx == 2'd0) src_reg <= bus.write_value_in[31:2];
               if (reg_wr && reg_idx == 2'd1) dst_reg <= bus.write_value_in[31:2];
               if (reg_wr && reg_idx == 2'd2) len_reg <= bus.write_value_in[LEN_WIDTH-1:0];
               // Start takes priority over a simultaneous done-clear.
               if (start) begin
                  if (len_reg != '0) begin
                     state_reg <= ST_RD;
                     done_reg  <= 1'b0;
                  end else begin
                     done_reg  <= 1'b1;
                  end
               end else if (clr_done) begin
                  done_reg <= 1'b0;
               end
            end
            ST_RD: begin
               if (bus.ready_in) begin
                  data_reg  <= bus.read_value_in;
                  src_reg   <= src_reg + 30'd1;
                  state_reg <= ST_WR;
               end
            end
            ST_WR: begin
               if (bus.ready_in) begin
                  dst_reg <= dst_reg + 30'd1;
                  len_reg <= len_reg - LEN_WIDTH'(1);
                  if (len_reg == LEN_WIDTH'(1)) begin
                     done_reg  <= 1'b1;
                     state_reg <= ST_IDLE;
                  end else begin
                     state_reg <= ST_RD;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

`ifdef DMA_IRQ_EN
   logic ie_reg;
   logic irq_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ie_reg  <= 1'b0;
         irq_reg <= 1'b0;
      end else begin
         if (ctrl_wr) ie_reg <= bus.write_value_in[2];
         irq_reg <= done_reg & ie_reg;
      end
   end

   assign ie_bit  = ie_reg;
   assign irq_out = irq_reg;
`else
   assign ie_bit = 1'b0;
`endif

   // Initiator outputs are decoded from state so reset drops them at once.
   assign bus.address_out     = (state_reg == ST_RD) ? {src_reg, 2'b00} :
                                (state_reg == ST_WR) ? {dst_reg, 2'b00} : 32'h0;
   assign bus.read_out        = (state_reg == ST_RD);
   assign bus.write_out       = (state_reg == ST_WR);
   assign bus.write_mask_out  = (state_reg == ST_WR) ? 4'hF : 4'h0;
   assign bus.write_value_out = (state_reg == ST_WR) ? data_reg : 32'h0;

   always_comb begin
      bus.read_value_out = 32'h0;
      if (bus.sel_in && bus.read_in) begin
         case (reg_idx)
            2'd0:    bus.read_value_out = {src_reg, 2'b00};
            2'd1:    bus.read_value_out = {dst_reg, 2'b00};
            2'd2:    bus.read_value_out = 32'(len_reg);
            default: bus.read_value_out = {29'h0, ie_bit, done_reg, busy};
         endcase
      end
   end

endmodule

// File: tb/tb_bus_dma.sv
// Self-checking bench for bus_dma: directed scenarios plus randomized copies checked
// against an arithmetic model of the expected read/write address and data streams.
module tb_bus_dma;
   logic clk = 1'b0;
   logic reset = 1'b1;
   bus_dma_if bus ();
`ifdef DMA_IRQ_EN
   logic irq_out;
`endif

   bus_dma #(.LEN_WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef DMA_IRQ_EN
      ,
      .irq_out(irq_out)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int req_cycles = 0;

   logic ready_mode = 1'b0;
   logic manual_ready = 1'b0;
   logic rnd_ready = 1'b0;
   assign bus.ready_in = ready_mode ? rnd_ready : manual_ready;

   // Memory contents are a fixed function of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
   endfunction
   assign bus.read_value_in = mem_word(bus.address_out);

   always @(negedge clk) rnd_ready = ($urandom_range(0, 1) == 1);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   logic [31:0] rd_q[$];
   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];
   logic        pend = 1'b0;
   logic [31:0] p_addr, p_wdata;
   logic [3:0]  p_mask;
   logic        p_rd, p_wr;

   // Bus monitor: records accepted requests and checks stalled requests hold steady.
   always begin
      @(negedge clk);
      #2;
      if (reset) begin
         pend = 1'b0;
      end else begin
         if (bus.read_out || bus.write_out) req_cycles++;
         if (pend) begin
            check("hold_addr", bus.address_out, p_addr);
            check("hold_rw", {30'h0, bus.read_out, bus.write_out}, {30'h0, p_rd, p_wr});
            check("hold_mask", {28'h0, bus.write_mask_out}, {28'h0, p_mask});
            check("hold_wdata", bus.write_value_out, p_wdata);
         end
         if (bus.read_out && bus.ready_in) begin
            rd_q.push_back(bus.address_out);
            check("rd_mask", {28'h0, bus.write_mask_out}, 32'h0);
         end
         if (bus.write_out && bus.ready_in) begin
            wa_q.push_back(bus.address_out);
            wd_q.push_back(bus.write_value_out);
            check("wr_mask", {28'h0, bus.write_mask_out}, 32'hF);
         end
         pend    = (bus.read_out || bus.write_out) && !bus.ready_in;
         p_addr  = bus.address_out;
         p_wdata = bus.write_value_out;
         p_mask  = bus.write_mask_out;
         p_rd    = bus.read_out;
         p_wr    = bus.write_out;
      end
   end

   task automatic wr_reg(input logic [1:0] idx, input logic [31:0] val, input logic [3:0] mask);
      @(negedge clk);
      bus.address_in     = {$urandom_range(0, 255), 22'h0, idx, 2'b00} & 32'h0FFF_FFFF;
      bus.sel_in         = 1'b1;
      bus.write_mask_in  = mask;
      bus.write_value_in = val;
      @(negedge clk);
      bus.sel_in         = 1'b0;
      bus.write_mask_in  = 4'h0;
   endtask

   task automatic rd_reg(input logic [1:0] idx, output logic [31:0] v);
      bus.address_in = {28'h0, idx, 2'b00};
      bus.sel_in     = 1'b1;
      bus.read_in    = 1'b1;
      #1;
      v = bus.read_value_out;
      bus.sel_in     = 1'b0;
      bus.read_in    = 1'b0;
   endtask

   task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [31:0] exp);
      logic [31:0] v;
      rd_reg(idx, v);
      check(tag, v, exp);
   endtask

   task automatic wait_done(input int max_cycles);
      logic [31:0] v;
      logic got = 1'b0;
      for (int k = 0; k < max_cycles && !got; k++) begin
         @(negedge clk);
         rd_reg(2'd3, v);
         got = v[1];
      end
      check("done_wait", {31'h0, got}, 32'h1);
   endtask

   task automatic clr_q();
      rd_q.delete();
      wa_q.delete();
      wd_q.delete();
   endtask

   // Reference: word i reads src+4i and writes mem(src+4i) to dst+4i, modulo 2^32.
   task automatic check_xfer(input logic [31:0] src, input logic [31:0] dst,
                             input int nrd, input int nwr);
      logic [31:0] a;
      check("n_reads", 32'(rd_q.size()), 32'(nrd));
      check("n_writes", 32'(wa_q.size()), 32'(nwr));
      for (int i = 0; i < nrd && i < rd_q.size(); i++) begin
         a = src + 32'(4 * i);
         check($sformatf("rd_addr[%0d]", i), rd_q[i], a);
      end
      for (int i = 0; i < nwr && i < wa_q.size(); i++) begin
         a = dst + 32'(4 * i);
         check($sformatf("wr_addr[%0d]", i), wa_q[i], a);
         a = src + 32'(4 * i);
         check($sformatf("wr_data[%0d]", i), wd_q[i], mem_word(a));
      end
      clr_q();
   endtask

   initial begin
      logic [31:0] s, d, ctl;
      int n, rq0;

      bus.address_in = 32'h0;
      bus.sel_in = 1'b0;
      bus.read_in = 1'b0;
      bus.write_mask_in = 4'h0;
      bus.write_value_in = 32'h0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_read_out", {31'h0, bus.read_out}, 32'h0);
      check("rst_write_out", {31'h0, bus.write_out}, 32'h0);
      check("rst_addr", bus.address_out, 32'h0);
      check("rst_mask", {28'h0, bus.write_mask_out}, 32'h0);
      check("rst_wdata", bus.write_value_out, 32'h0);
      reset = 1'b0;
      chk_reg("rst_src", 2'd0, 32'h0);
      chk_reg("rst_len", 2'd2, 32'h0);
      chk_reg("rst_ctrl", 2'd3, 32'h0);
      check("idle_rdata", bus.read_value_out, 32'h0);

      // Test 1: 3-word copy, no stalls, exact latency
      manual_ready = 1'b1;
      clr_q();
      wr_reg(2'd0, 32'h0000_0103, 4'b0001);
      chk_reg("src_lowbits", 2'd0, 32'h0000_0100);
      wr_reg(2'd1, 32'h0000_0200, 4'hF);
      wr_reg(2'd2, 32'hFFFF_0003, 4'hF);
      chk_reg("len_upper0", 2'd2, 32'h3);
      wr_reg(2'd3, 32'h1, 4'hF);
      repeat (5) @(negedge clk);
      chk_reg("t1_busy", 2'd3, 32'h1);
      @(negedge clk);
      chk_reg("t1_done", 2'd3, 32'h2);
      check_xfer(32'h100, 32'h200, 3, 3);

      // Test 2: stalled read and write
      manual_ready = 1'b0;
      wr_reg(2'd0, 32'h300, 4'hF);
      wr_reg(2'd1, 32'h400, 4'hF);
      wr_reg(2'd2, 32'h1, 4'hF);
      wr_reg(2'd3, 32'h1, 4'hF);
      repeat (5) begin
         @(negedge clk);
         check("t2_rd_stall", {bus.address_out[30:0], bus.read_out}, {31'h300, 1'b1});
      end
      manual_ready = 1'b1;
      @(negedge clk);
      manual_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t2_wr_stall", {bus.address_out[30:0], bus.write_out}, {31'h400, 1'b1});
      end
      manual_ready = 1'b1;
      @(negedge clk);
      chk_reg("t2_done", 2'd3, 32'h2);
      check_xfer(32'h300, 32'h400, 1, 1);

      // Test 3: zero-length start
      rq0 = req_cycles;
      wr_reg(2'd2, 32'h0, 4'hF);
      wr_reg(2'd3, 32'h1, 4'hF);
      chk_reg("t3_done", 2'd3, 32'h2);
      repeat (3) @(negedge clk);
      check("t3_no_traffic", 32'(req_cycles - rq0), 32'h0);
      wr_reg(2'd3, 32'h2, 4'hF);
      chk_reg("t3_cleared", 2'd3, 32'h0);

      // Test 4: writes while busy are ignored
      clr_q();
      wr_reg(2'd0, 32'h1000, 4'hF);
      wr_reg(2'd1, 32'h2000, 4'hF);
      wr_reg(2'd2, 32'h4, 4'hF);
      wr_reg(2'd3, 32'h1, 4'hF);
      wr_reg(2'd0, 32'hDEAD_0000, 4'hF);
      wr_reg(2'd3, 32'h1, 4'hF);
      wr_reg(2'd2, 32'h7, 4'hF);
      wait_done(40);
      check_xfer(32'h1000, 32'h2000, 4, 4);
      chk_reg("t4_len0", 2'd2, 32'h0);
      chk_reg("t4_src", 2'd0, 32'h1010);
      chk_reg("t4_dst", 2'd1, 32'h2010);

      // Test 5: source wrap, then reset mid-transfer
      wr_reg(2'd0, 32'hFFFF_FFFC, 4'hF);
      wr_reg(2'd1, 32'h500, 4'hF);
      wr_reg(2'd2, 32'h2, 4'hF);
      wr_reg(2'd3, 32'h1, 4'hF);
      repeat (3) @(negedge clk);
      check("t5_wr2_addr", bus.address_out, 32'h504);
      check("t5_wr2_active", {31'h0, bus.write_out}, 32'h1);
      reset = 1'b1;
      #1;
      check("t5_rst_rw", {30'h0, bus.read_out, bus.write_out}, 32'h0);
      check("t5_rst_addr", bus.address_out, 32'h0);
      chk_reg("t5_rst_src", 2'd0, 32'h0);
      chk_reg("t5_rst_dst", 2'd1, 32'h0);
      chk_reg("t5_rst_len", 2'd2, 32'h0);
      chk_reg("t5_rst_ctrl", 2'd3, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      check_xfer(32'hFFFF_FFFC, 32'h500, 2, 1);

      // Test 6: interrupt enable
`ifdef DMA_IRQ_EN
      wr_reg(2'd3, 32'h4, 4'hF);
      wr_reg(2'd0, 32'h600, 4'hF);
      wr_reg(2'd1, 32'h700, 4'hF);
      wr_reg(2'd2, 32'h1, 4'hF);
      wr_reg(2'd3, 32'h5, 4'hF);
      repeat (2) @(negedge clk);
      chk_reg("t6_done_ie", 2'd3, 32'h6);
      check("t6_irq_lag", {31'h0, irq_out}, 32'h0);
      @(negedge clk);
      check("t6_irq_rise", {31'h0, irq_out}, 32'h1);
      wr_reg(2'd3, 32'h6, 4'hF);
      check("t6_irq_hold", {31'h0, irq_out}, 32'h1);
      chk_reg("t6_ctrl_ie", 2'd3, 32'h4);
      @(negedge clk);
      check("t6_irq_fall", {31'h0, irq_out}, 32'h0);
      wr_reg(2'd3, 32'h0, 4'hF);
      clr_q();
`else
      wr_reg(2'd3, 32'h4, 4'hF);
      chk_reg("t6_no_ie", 2'd3, 32'h0);
`endif

      // Randomized copies with random ready stalls
      ready_mode = 1'b1;
      for (int t = 0; t < 10; t++) begin
         s = $urandom & 32'hFFFF_FFFC;
         d = $urandom & 32'hFFFF_FFFC;
         n = $urandom_range(1, 6);
         clr_q();
         wr_reg(2'd0, s | 32'($urandom_range(0, 3)), 4'($urandom_range(1, 15)));
         wr_reg(2'd1, d, 4'hF);
         wr_reg(2'd2, 32'(n), 4'hF);
         ctl = ($urandom_range(0, 1) == 1) ? 32'h3 : 32'h1;
         wr_reg(2'd3, ctl, 4'hF);
         chk_reg("rnd_busy", 2'd3, 32'h1);
         wait_done(200);
         check_xfer(s, d, n, n);
         chk_reg("rnd_src_end", 2'd0, s + 32'(4 * n));
         chk_reg("rnd_dst_end", 2'd1, d + 32'(4 * n));
         chk_reg("rnd_len_end", 2'd2, 32'h0);
         wr_reg(2'd3, 32'h2, 4'hF);
         chk_reg("rnd_clear", 2'd3, 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule
